// File: rtl/rx_frame_parser.sv
`default_nettype none
// ============================================================================
// rx_frame_parser: reads one stored frame, filters the MAC header, forwards
// the payload with the FCS stripped and reports done/drop per frame.
// Revision: 1.0
// ============================================================================
module rx_frame_parser #(
    parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE = 16'h0800,
    parameter int          TIMEOUT   = 64,
    parameter int          COOLDOWN  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_ready,
    output logic        read_request,
    input  logic        axiiv,
    input  logic [15:0] axiid,
    output logic        axiov,
    output logic [15:0] axiod,
    output logic [47:0] dest_mac,
    output logic [47:0] src_mac,
    output logic [15:0] ethertype,
    output logic        hdr_valid,
    output logic [7:0]  payload_len,
    output logic        frame_done,
    output logic        frame_drop,
    output logic        busy
);
    localparam int c_tmo_w  = $clog2(TIMEOUT + 1);
    localparam int c_cool_w = $clog2(COOLDOWN + 2);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_req     = 3'd1;
    localparam logic [2:0] c_st_hdr     = 3'd2;
    localparam logic [2:0] c_st_payload = 3'd3;
    localparam logic [2:0] c_st_drain   = 3'd4;
    localparam logic [2:0] c_st_end     = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_tmo_w-1:0]  r_tmo_cnt;
    logic [c_cool_w-1:0] r_cool_cnt;
    logic [2:0]          r_word_cnt;
    logic [15:0]         r_s0;
    logic [15:0]         r_s1;
    logic                r_s0_v;
    logic                r_s1_v;
    logic [7:0]          r_emit_cnt;

    logic w_pass;
    logic w_hdr_eval;
    logic w_tmo_hit;
    logic w_accept;
    logic w_emit;
    logic w_done;
    logic w_drop;
    logic w_req_nxt;
    logic w_busy_nxt;

    assign w_pass = ((dest_mac == MAC_ADDR) || (dest_mac == 48'hFFFF_FFFF_FFFF)) &&
                    ((ETHERTYPE == 16'h0000) || (ethertype == ETHERTYPE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (frame_ready && (r_cool_cnt == '0)) begin
                    w_state_nxt = c_st_req;
                end
            end
            c_st_req: begin
                if (axiiv) begin
                    w_state_nxt = c_st_hdr;
                end else if (r_tmo_cnt == c_tmo_w'(TIMEOUT - 1)) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_hdr: begin
                // word_cnt==7 is the filter cycle; its word is already payload
                if (!axiiv) begin
                    w_state_nxt = c_st_end;
                end else if (r_word_cnt == 3'd7) begin
                    w_state_nxt = w_pass ? c_st_payload : c_st_drain;
                end
            end
            c_st_payload: begin
                if (!axiiv) begin
                    w_state_nxt = c_st_end;
                end
            end
            c_st_drain: begin
                if (!axiiv) begin
                    w_state_nxt = c_st_end;
                end
            end
            c_st_end: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_comb begin
        w_hdr_eval = (r_state == c_st_hdr) && (r_word_cnt == 3'd7);
        w_tmo_hit  = (r_state == c_st_req) && !axiiv && (r_tmo_cnt == c_tmo_w'(TIMEOUT - 1));
        w_accept   = (w_hdr_eval && w_pass && axiiv) || ((r_state == c_st_payload) && axiiv);
        w_emit     = (r_state == c_st_payload) && axiiv && r_s1_v;
        w_done     = (r_state == c_st_payload) && !axiiv && r_s1_v;
        w_drop     = w_tmo_hit ||
                     ((r_state == c_st_hdr) && !axiiv) ||
                     ((r_state == c_st_payload) && !axiiv && !r_s1_v) ||
                     ((r_state == c_st_drain) && !axiiv);
        w_req_nxt  = (w_state_nxt == c_st_req) || (w_state_nxt == c_st_hdr) ||
                     (w_state_nxt == c_st_payload) || (w_state_nxt == c_st_drain);
        w_busy_nxt = (w_state_nxt != c_st_idle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_request <= 1'b0;
            busy         <= 1'b0;
            axiov        <= 1'b0;
            axiod        <= '0;
            dest_mac     <= '0;
            src_mac      <= '0;
            ethertype    <= '0;
            hdr_valid    <= 1'b0;
            payload_len  <= '0;
            frame_done   <= 1'b0;
            frame_drop   <= 1'b0;
            r_tmo_cnt    <= '0;
            r_cool_cnt   <= '0;
            r_word_cnt   <= '0;
            r_s0         <= '0;
            r_s1         <= '0;
            r_s0_v       <= 1'b0;
            r_s1_v       <= 1'b0;
            r_emit_cnt   <= '0;
        end else begin
            read_request <= w_req_nxt;
            busy         <= w_busy_nxt;
            axiov        <= w_emit;
            hdr_valid    <= w_hdr_eval && w_pass;
            frame_done   <= w_done;
            frame_drop   <= w_drop;

            r_tmo_cnt <= (r_state == c_st_req) ? r_tmo_cnt + 1'b1 : '0;

            if (r_state == c_st_end) begin
                r_cool_cnt <= c_cool_w'(COOLDOWN);
            end else if (r_cool_cnt != '0) begin
                r_cool_cnt <= r_cool_cnt - 1'b1;
            end

            if ((r_state == c_st_req) && axiiv) begin
                dest_mac[47:32] <= axiid;
                r_word_cnt      <= 3'd1;
            end else if ((r_state == c_st_hdr) && axiiv && (r_word_cnt != 3'd7)) begin
                case (r_word_cnt)
                    3'd1:    dest_mac[31:16] <= axiid;
                    3'd2:    dest_mac[15:0]  <= axiid;
                    3'd3:    src_mac[47:32]  <= axiid;
                    3'd4:    src_mac[31:16]  <= axiid;
                    3'd5:    src_mac[15:0]   <= axiid;
                    default: ethertype       <= axiid;
                endcase
                r_word_cnt <= r_word_cnt + 1'b1;
            end

            // Two-word delay line: whatever sits in it when the stream stops is the FCS
            if (r_state == c_st_req) begin
                r_s0_v <= 1'b0;
                r_s1_v <= 1'b0;
            end else if (w_accept) begin
                r_s0   <= axiid;
                r_s0_v <= 1'b1;
                r_s1   <= r_s0;
                r_s1_v <= r_s0_v;
            end

            if (w_emit) begin
                axiod <= r_s1;
            end

            if (r_state == c_st_req) begin
                r_emit_cnt <= '0;
            end else if (w_emit && (r_emit_cnt != 8'hFF)) begin
                r_emit_cnt <= r_emit_cnt + 1'b1;
            end

            if (w_done) begin
                payload_len <= r_emit_cnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_parser.sv
`default_nettype none
// ============================================================================
// tb_rx_frame_parser: randomized frames checked against a frame-level model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_rx_frame_parser;
    localparam logic [47:0] c_mac  = 48'h02_00_00_00_00_01;
    localparam logic [15:0] c_etyp = 16'h0800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_ready = 1'b0;
    logic        axiiv = 1'b0;
    logic [15:0] axiid = '0;
    logic        read_request, axiov, hdr_valid, frame_done, frame_drop, busy;
    logic [15:0] axiod, ethertype;
    logic [47:0] dest_mac, src_mac;
    logic [7:0]  payload_len;

    rx_frame_parser #(
        .MAC_ADDR (c_mac),
        .ETHERTYPE(c_etyp),
        .TIMEOUT  (64),
        .COOLDOWN (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_ready (frame_ready),
        .read_request(read_request),
        .axiiv       (axiiv),
        .axiid       (axiid),
        .axiov       (axiov),
        .axiod       (axiod),
        .dest_mac    (dest_mac),
        .src_mac     (src_mac),
        .ethertype   (ethertype),
        .hdr_valid   (hdr_valid),
        .payload_len (payload_len),
        .frame_done  (frame_done),
        .frame_drop  (frame_drop),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: cumulative event counts and the emitted word stream
    int          hv_cnt = 0, done_cnt = 0, drop_cnt = 0, cyc = 0;
    logic [7:0]  last_len = '0;
    logic [15:0] obs_q[$];
    int          obs_cyc[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (axiov) begin
                obs_q.push_back(axiod);
                obs_cyc.push_back(cyc);
            end
            if (hdr_valid)  hv_cnt   <= hv_cnt + 1;
            if (frame_drop) drop_cnt <= drop_cnt + 1;
            if (frame_done) begin
                done_cnt <= done_cnt + 1;
                last_len <= payload_len;
            end
        end
    end

    logic [15:0] frm[$];
    logic [15:0] exp_hdr[7];

    task automatic make_frame(input logic [47:0] d, input logic [47:0] s,
                              input logic [15:0] e, input int m);
        frm.delete();
        frm.push_back(d[47:32]); frm.push_back(d[31:16]); frm.push_back(d[15:0]);
        frm.push_back(s[47:32]); frm.push_back(s[31:16]); frm.push_back(s[15:0]);
        frm.push_back(e);
        for (int i = 0; i < m; i++) frm.push_back(16'($urandom));
    endtask

    task automatic pulse_ready();
        repeat (4) @(posedge clk);
        #1 frame_ready = 1'b1;
        @(posedge clk); #1 frame_ready = 1'b0;
    endtask

    // Serves frm as the upstream store would and checks the frame-level outcome.
    // Returns at the negedge one cycle after the status pulse.
    task automatic do_frame(input string nm, input bit pulse, input int ready_at);
        int hv0, dn0, dr0, q0, len, m, em, t;
        bit pass, exp_done;
        logic [47:0] d;
        hv0 = hv_cnt; dn0 = done_cnt; dr0 = drop_cnt; q0 = obs_q.size();
        len = frm.size();
        for (int i = 0; i < 7 && i < len; i++) exp_hdr[i] = frm[i];
        d = {exp_hdr[0], exp_hdr[1], exp_hdr[2]};
        pass = (len >= 7) && ((d == c_mac) || (d == 48'hFFFF_FFFF_FFFF)) && (exp_hdr[6] == c_etyp);
        m = (len > 7) ? len - 7 : 0;
        exp_done = pass && (m >= 2);
        em = exp_done ? m - 2 : 0;

        if (pulse) pulse_ready();
        t = 0;
        while (!read_request && t < 20) begin @(negedge clk); t++; end
        check_eq({nm, ":req"}, 64'(read_request), 64'd1);
        repeat ($urandom_range(0, 4)) @(posedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < len; i++) begin
            axiiv = 1'b1; axiid = frm[i]; frame_ready = (i == ready_at);
            @(posedge clk); #1;
        end
        axiiv = 1'b0; axiid = 16'($urandom); frame_ready = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!(frame_done || frame_drop) && t < 10);
        check_eq({nm, ":status"}, 64'(frame_done | frame_drop), 64'd1);
        @(negedge clk);
        check_eq({nm, ":hdr_valid"}, 64'(hv_cnt - hv0), 64'(pass));
        check_eq({nm, ":done"}, 64'(done_cnt - dn0), 64'(exp_done));
        check_eq({nm, ":drop"}, 64'(drop_cnt - dr0), 64'(!exp_done));
        if (exp_done) check_eq({nm, ":len"}, 64'(last_len), 64'((em > 255) ? 255 : em));
        check_eq({nm, ":nwords"}, 64'(obs_q.size() - q0), 64'(em));
        if (obs_q.size() - q0 == em && em > 0) begin
            for (int i = 0; i < em; i++) begin
                if (obs_q[q0 + i] !== frm[7 + i]) begin
                    check_eq($sformatf("%s:word%0d", nm, i), 64'(obs_q[q0 + i]), 64'(frm[7 + i]));
                    break;
                end
            end
            check_eq({nm, ":contig"}, 64'(obs_cyc[q0 + em - 1] - obs_cyc[q0]), 64'(em - 1));
        end
        check_eq({nm, ":dest"}, 64'(dest_mac), 64'({exp_hdr[0], exp_hdr[1], exp_hdr[2]}));
        check_eq({nm, ":src"}, 64'(src_mac), 64'({exp_hdr[3], exp_hdr[4], exp_hdr[5]}));
        check_eq({nm, ":etype"}, 64'(ethertype), 64'(exp_hdr[6]));
    endtask

    initial begin
        int n, t, hv0, dr0, dn0;
        bit seen;
        for (int i = 0; i < 7; i++) exp_hdr[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ctrl", 64'({read_request, axiov, hdr_valid, frame_done, frame_drop, busy}), 64'd0);
        check_eq("rst_data", 64'({axiod, payload_len}), 64'd0);
        check_eq("rst_hdr", 64'({dest_mac, ethertype}), 64'd0);
        check_eq("rst_src", 64'(src_mac), 64'd0);
        rst_n = 1'b1;

        // Unicast, 10 payload words + FCS
        make_frame(c_mac, 48'hAABB_CCDD_EEFF, 16'h0800, 12);
        for (int i = 0; i < 10; i++) frm[7 + i] = 16'h1000 + 16'(i);
        do_frame("unicast", 1'b1, -1);

        // Broadcast with wrong ethertype
        make_frame(48'hFFFF_FFFF_FFFF, 48'h1111_2222_3333, 16'h0806, 8);
        do_frame("bcast_arp", 1'b1, -1);

        // 4-word runt
        make_frame(c_mac, 48'h4444_5555_6666, 16'h0800, 0);
        while (frm.size() > 4) void'(frm.pop_back());
        do_frame("runt4", 1'b1, -1);

        // No response: timeout
        dr0 = drop_cnt; hv0 = hv_cnt;
        pulse_ready();
        n = 0;
        @(negedge clk);
        while (read_request && n < 200) begin n++; @(negedge clk); end
        check_eq("tmo_cycles", 64'(n), 64'd64);
        check_eq("tmo_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check_eq("tmo_drop", 64'(drop_cnt - dr0), 64'd1);
        check_eq("tmo_hv", 64'(hv_cnt - hv0), 64'd0);

        // Second pulse during payload is not queued
        make_frame(c_mac, 48'h0A0B_0C0D_0E0F, 16'h0800, 14);
        do_frame("b2b", 1'b1, 10);
        seen = 1'b0;
        repeat (10) begin @(negedge clk); if (read_request) seen = 1'b1; end
        check_eq("b2b_not_queued", 64'(seen), 64'd0);

        // Cooldown: pulse one cycle after END ignored, pulse at expiry accepted
        make_frame(48'hFFFF_FFFF_FFFF, 48'h7777_8888_9999, 16'h0800, 5);
        do_frame("cool_a", 1'b1, -1);
        frame_ready = 1'b1;
        @(posedge clk); #1 frame_ready = 1'b0;
        @(negedge clk);
        check_eq("cool_ignore", 64'(read_request), 64'd0);
        @(posedge clk); #1 frame_ready = 1'b1;
        @(posedge clk); #1 frame_ready = 1'b0;
        @(negedge clk);
        check_eq("cool_accept", 64'(read_request), 64'd1);
        make_frame(c_mac, 48'h1234_5678_9ABC, 16'h0800, 6);
        do_frame("cool_b", 1'b0, -1);

        // Saturating payload length
        make_frame(c_mac, 48'h0000_0000_0042, 16'h0800, 262);
        do_frame("long", 1'b1, -1);

        // Randomized mix
        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 5))
                0: make_frame(c_mac, 48'({$urandom, $urandom}), c_etyp, $urandom_range(2, 20));
                1: make_frame(48'hFFFF_FFFF_FFFF, 48'({$urandom, $urandom}), c_etyp, $urandom_range(2, 20));
                2: make_frame(48'({$urandom, $urandom}), 48'({$urandom, $urandom}), c_etyp, $urandom_range(0, 10));
                3: make_frame(c_mac, 48'({$urandom, $urandom}), 16'($urandom), $urandom_range(0, 10));
                4: begin
                    make_frame(c_mac, 48'({$urandom, $urandom}), c_etyp, 0);
                    n = $urandom_range(1, 6);
                    while (frm.size() > n) void'(frm.pop_back());
                end
                default: make_frame(($urandom_range(0, 1) == 1) ? c_mac : 48'hFFFF_FFFF_FFFF,
                                    48'({$urandom, $urandom}), c_etyp, $urandom_range(0, 2));
            endcase
            do_frame($sformatf("rand%0d", f), 1'b1, -1);
        end

        // Reset in the middle of the payload
        make_frame(c_mac, 48'hCAFE_0000_BEEF, 16'h0800, 22);
        pulse_ready();
        t = 0;
        while (!read_request && t < 20) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            axiiv = 1'b1; axiid = frm[i];
            @(posedge clk); #1;
        end
        #2;
        check_eq("pre_rst_axiov", 64'(axiov), 64'd1);
        dn0 = done_cnt; dr0 = drop_cnt;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", 64'({axiov, read_request, busy}), 64'd0);
        axiiv = 1'b0;
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_no_status", 64'((done_cnt - dn0) + (drop_cnt - dr0)), 64'd0);
        for (int i = 0; i < 7; i++) exp_hdr[i] = '0;
        make_frame(c_mac, 48'hFEED_FACE_0001, 16'h0800, 9);
        do_frame("post_rst", 1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
